pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the five-stage pipeline CPU. It keeps its own scoreboard of the destinations in the EX and MEM stages, and from it generates load-use stalls and the ID-stage forwarding selects. It also provides a debug halt/drain/single-step sequence and a saturating stall-cycle counter. It sits beside the ID stage, drives the PC/IF-ID write enable and the ID/EX bubble, and replaces ad-hoc stall logic in the decode stage.

---
 rtl/pipe_ctrl.sv | 153 +++++++++++++++
 tb/tb_pipe_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: EX/MEM destination scoreboard, load-use stall,
// ID forwarding selects, debug halt/drain/step FSM and saturating stall counter.
// Optional single-step support is built when PIPE_CTRL_STEP_EN is defined.
module pipe_ctrl (
  input  logic        clock,
  input  logic        resetn,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        id_wreg,
  input  logic        id_m2reg,
  input  logic [4:0]  id_rn,
  input  logic        halt_req,
  input  logic        step_req,
  output logic        pc_we,
  output logic        idex_bubble,
  output logic [1:0]  fwda,
  output logic [1:0]  fwdb,
  output logic        halted,
  output logic        step_ack,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED, S_STEP} state_t;

  typedef struct packed {
    logic       v;
    logic [4:0] rn;
    logic       m2reg;
  } slot_t;

  state_t     state;
  logic [1:0] dcnt;
  slot_t      ex_slot, mem_slot;
  logic       hazard, issue;

  function automatic logic hit(slot_t s, logic [4:0] r);
    return s.v && (s.rn != 5'd0) && (s.rn == r);
  endfunction

  // EX load match yields 00: that case is always covered by the load-use stall.
  function automatic logic [1:0] fsel(slot_t ex, slot_t mem, logic [4:0] r);
    if (hit(ex, r))       return ex.m2reg ? 2'b00 : 2'b01;
    else if (hit(mem, r)) return mem.m2reg ? 2'b11 : 2'b10;
    else                  return 2'b00;
  endfunction

  always_comb begin
    hazard = ex_slot.m2reg &&
             ((id_uses_rs && hit(ex_slot, id_rs)) || (id_uses_rt && hit(ex_slot, id_rt)));
    pc_we       = 1'b0;
    idex_bubble = 1'b1;
    case (state)
      S_RUN: begin
        pc_we       = ~hazard;
        idex_bubble = hazard;
      end
`ifdef PIPE_CTRL_STEP_EN
      S_STEP: begin
        pc_we       = 1'b1;
        idex_bubble = 1'b0;
      end
`endif
      default: begin
        pc_we       = 1'b0;
        idex_bubble = 1'b1;
      end
    endcase
  end

  assign issue  = pc_we & ~idex_bubble;
  assign fwda   = fsel(ex_slot, mem_slot, id_rs);
  assign fwdb   = fsel(ex_slot, mem_slot, id_rt);
  assign halted = (state == S_HALTED);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ex_slot  <= '0;
      mem_slot <= '0;
    end else begin
      mem_slot <= ex_slot;
      ex_slot  <= issue ? slot_t'{v: id_wreg, rn: id_rn, m2reg: id_m2reg} : '0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      stall_cnt <= '0;
    else if ((state == S_RUN) && hazard && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end

`ifdef PIPE_CTRL_STEP_EN
  logic step_flag, step_ack_r;
  assign step_ack = step_ack_r;
`else
  logic unused_step;
  assign unused_step = step_req;
  assign step_ack    = 1'b0;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= S_RUN;
      dcnt  <= '0;
`ifdef PIPE_CTRL_STEP_EN
      step_flag  <= 1'b0;
      step_ack_r <= 1'b0;
`endif
    end else begin
`ifdef PIPE_CTRL_STEP_EN
      step_ack_r <= 1'b0;
`endif
      case (state)
        S_RUN: begin
          if (halt_req) begin
            state <= S_DRAIN;
            dcnt  <= 2'd2;
          end
        end
        S_DRAIN: begin
          if (dcnt == 2'd0) begin
            state <= S_HALTED;
`ifdef PIPE_CTRL_STEP_EN
            step_ack_r <= step_flag;
            step_flag  <= 1'b0;
`endif
          end else begin
            dcnt <= dcnt - 2'd1;
          end
        end
        S_HALTED: begin
          if (!halt_req)
            state <= S_RUN;
`ifdef PIPE_CTRL_STEP_EN
          else if (step_req)
            state <= S_STEP;
`endif
        end
`ifdef PIPE_CTRL_STEP_EN
        S_STEP: begin
          state     <= S_DRAIN;
          dcnt      <= 2'd2;
          step_flag <= 1'b1;
        end
`endif
        default: state <= S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus a randomized run
// against a queue-based behavioural model of the pipeline and debug sequencer.
module tb_pipe_ctrl;
  logic        clock = 1'b0, resetn = 1'b0;
  logic [4:0]  id_rs, id_rt, id_rn;
  logic        id_uses_rs, id_uses_rt, id_wreg, id_m2reg, halt_req, step_req;
  logic        pc_we, idex_bubble, halted, step_ack;
  logic [1:0]  fwda, fwdb;
  logic [15:0] stall_cnt;
  int checks = 0, failures = 0;

`ifdef PIPE_CTRL_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  pipe_ctrl dut (
    .clock(clock), .resetn(resetn), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_wreg(id_wreg),
    .id_m2reg(id_m2reg), .id_rn(id_rn), .halt_req(halt_req), .step_req(step_req),
    .pc_we(pc_we), .idex_bubble(idex_bubble), .fwda(fwda), .fwdb(fwdb),
    .halted(halted), .step_ack(step_ack), .stall_cnt(stall_cnt)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic set_id(input int rs, input bit urs, input int rt, input bit urt,
                        input bit wreg, input bit ld, input int rn);
    id_rs = 5'(rs); id_uses_rs = urs; id_rt = 5'(rt); id_uses_rt = urt;
    id_wreg = wreg; id_m2reg = ld; id_rn = 5'(rn);
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    resetn = 1'b0; halt_req = 1'b0; step_req = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0);
    @(posedge clock); #1;
    resetn = 1'b1;
  endtask

  // Behavioural model: issue history (index 0 = most recent issue slot) and a debug mode.
  typedef struct {bit v; bit [4:0] rn; bit ld;} ent_t;
  localparam int MD_RUN = 0, MD_DRAIN = 1, MD_HALT = 2, MD_STEP = 3;
  ent_t hist[$];
  int   md, left, m_ack, m_cnt;
  bit   pend;

  function automatic void m_reset();
    ent_t z = '{0, 0, 0};
    hist.delete(); hist.push_back(z); hist.push_back(z);
    md = MD_RUN; left = 0; m_ack = 0; m_cnt = 0; pend = 0;
  endfunction

  function automatic bit hit(ent_t e, logic [4:0] r);
    return e.v && (e.rn != 0) && (e.rn == r);
  endfunction

  function automatic logic [1:0] m_fwd(logic [4:0] r);
    if (hit(hist[0], r)) return hist[0].ld ? 2'd0 : 2'd1;
    if (hit(hist[1], r)) return hist[1].ld ? 2'd3 : 2'd2;
    return 2'd0;
  endfunction

  task automatic test_reset();
    #1;
    checks++; if (pc_we !== 1'b1) begin failures++; $display("FAIL rst_pc_we got=%b exp=1", pc_we); end
    checks++; if (idex_bubble !== 1'b0) begin failures++; $display("FAIL rst_bubble got=%b exp=0", idex_bubble); end
    checks++; if (fwda !== 2'd0 || fwdb !== 2'd0) begin failures++; $display("FAIL rst_fwd got=%0d/%0d exp=0/0", fwda, fwdb); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL rst_halted got=%b exp=0", halted); end
    checks++; if (step_ack !== 1'b0) begin failures++; $display("FAIL rst_step_ack got=%b exp=0", step_ack); end
    checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL rst_stall_cnt got=%0h exp=0", stall_cnt); end
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(0, 0, 0, 0, 1, 1, 5);            // lw r5
    #2; checks++; if (pc_we !== 1'b1) begin failures++; $display("FAIL lu_issue got=%b exp=1", pc_we); end
    tick();
    set_id(5, 1, 0, 0, 1, 0, 7);            // add r7, r5, ...
    #2;
    checks++; if (pc_we !== 1'b0 || idex_bubble !== 1'b1) begin failures++; $display("FAIL lu_stall got=%b%b exp=01", pc_we, idex_bubble); end
    checks++; if (fwda !== 2'd0) begin failures++; $display("FAIL lu_fwd_ex_load got=%0d exp=0", fwda); end
    tick(); #2;
    checks++; if (fwda !== 2'd3) begin failures++; $display("FAIL lu_fwd_mem got=%0d exp=3", fwda); end
    checks++; if (pc_we !== 1'b1 || idex_bubble !== 1'b0) begin failures++; $display("FAIL lu_release got=%b%b exp=10", pc_we, idex_bubble); end
    checks++; if (stall_cnt !== 16'd1) begin failures++; $display("FAIL lu_stall_cnt got=%0d exp=1", stall_cnt); end
  endtask

  task automatic test_forward();
    do_reset();
    set_id(0, 0, 0, 0, 1, 0, 3); tick();    // sub r3
    set_id(0, 0, 0, 0, 1, 0, 3); tick();    // add r3
    set_id(0, 1, 3, 1, 0, 0, 0); #2;
    checks++; if (fwdb !== 2'd1) begin failures++; $display("FAIL fwd_ex_prio got=%0d exp=1", fwdb); end
    checks++; if (fwda !== 2'd0) begin failures++; $display("FAIL fwd_rs0 got=%0d exp=0", fwda); end
    do_reset();
    set_id(0, 0, 0, 0, 1, 0, 3); tick();    // sub r3
    set_id(0, 0, 0, 0, 1, 0, 0); tick();    // add r0
    set_id(0, 1, 3, 1, 0, 0, 0); #2;
    checks++; if (fwdb !== 2'd2) begin failures++; $display("FAIL fwd_mem got=%0d exp=2", fwdb); end
    checks++; if (fwda !== 2'd0) begin failures++; $display("FAIL fwd_r0_ex got=%0d exp=0", fwda); end
  endtask

  task automatic test_halt();
    int exp_fa[4];
    exp_fa = '{1, 2, 0, 0};
    do_reset();
    set_id(3, 1, 0, 0, 1, 0, 3); tick();
    halt_req = 1'b1; #2;
    checks++; if (pc_we !== 1'b1 || fwda !== 2'd1) begin failures++; $display("FAIL halt_pre got=%b/%0d exp=1/1", pc_we, fwda); end
    tick();
    for (int i = 0; i < 4; i++) begin
      #2;
      checks++; if (pc_we !== 1'b0 || idex_bubble !== 1'b1) begin failures++; $display("FAIL halt_freeze c=%0d got=%b%b exp=01", i, pc_we, idex_bubble); end
      checks++; if (halted !== (i == 3)) begin failures++; $display("FAIL halt_halted c=%0d got=%b exp=%b", i, halted, i == 3); end
      checks++; if (fwda !== 2'(exp_fa[i])) begin failures++; $display("FAIL halt_drain_fwd c=%0d got=%0d exp=%0d", i, fwda, exp_fa[i]); end
      if (i < 3) tick();
    end
    halt_req = 1'b0; tick(); #2;
    checks++; if (pc_we !== 1'b1 || halted !== 1'b0) begin failures++; $display("FAIL halt_resume got=%b/%b exp=1/0", pc_we, halted); end
  endtask

  task automatic test_step();
    int n = 0, pcw = 0, first_pcw = -1, acks = 0, ack_at = -1, hcnt = 0;
    int e_pcw, e_first, e_acks, e_ack_at, e_hcnt;
    e_pcw = STEP_EN ? 1 : 0; e_first = STEP_EN ? 0 : -1;
    e_acks = STEP_EN ? 1 : 0; e_ack_at = STEP_EN ? 4 : -1; e_hcnt = STEP_EN ? 4 : 8;
    do_reset();
    halt_req = 1'b1; tick();
    while (halted !== 1'b1 && n < 10) begin tick(); n++; end
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL step_reach_halt got=%b exp=1", halted); end
    step_req = 1'b1; #2;
    checks++; if (pc_we !== 1'b0) begin failures++; $display("FAIL step_halted_pc got=%b exp=0", pc_we); end
    tick(); step_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #2;
      if (pc_we === 1'b1) begin pcw++; if (first_pcw < 0) first_pcw = i; end
      if (step_ack === 1'b1) begin acks++; ack_at = i; end
      if (halted === 1'b1) hcnt++;
      tick();
    end
    checks++; if (pcw != e_pcw || first_pcw != e_first) begin failures++; $display("FAIL step_pc_pulse got=%0d@%0d exp=%0d@%0d", pcw, first_pcw, e_pcw, e_first); end
    checks++; if (acks != e_acks || ack_at != e_ack_at) begin failures++; $display("FAIL step_ack got=%0d@%0d exp=%0d@%0d", acks, ack_at, e_acks, e_ack_at); end
    checks++; if (hcnt != e_hcnt) begin failures++; $display("FAIL step_halted_cycles got=%0d exp=%0d", hcnt, e_hcnt); end
    halt_req = 1'b0;
  endtask

  task automatic test_saturate();
    do_reset();
    set_id(5, 1, 0, 0, 1, 1, 5);            // load that reads its own destination
    repeat (4) tick();
    #2; checks++; if (stall_cnt !== 16'd2) begin failures++; $display("FAIL sat_count got=%0d exp=2", stall_cnt); end
    force dut.stall_cnt = 16'hFFFE;
    #1; release dut.stall_cnt;
    tick(); tick(); #2;
    checks++; if (stall_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_reach got=%0h exp=ffff", stall_cnt); end
    tick(); tick(); #2;
    checks++; if (stall_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_hold got=%0h exp=ffff", stall_cnt); end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    set_id(5, 1, 0, 0, 1, 1, 5);
    tick(); tick();
    halt_req = 1'b1; tick(); tick();
    #1; checks++; if (pc_we !== 1'b0) begin failures++; $display("FAIL mid_drain_pc got=%b exp=0", pc_we); end
    resetn = 1'b0; #1;
    checks++; if (pc_we !== 1'b1 || idex_bubble !== 1'b0) begin failures++; $display("FAIL mid_rst_pc got=%b%b exp=10", pc_we, idex_bubble); end
    checks++; if (halted !== 1'b0 || step_ack !== 1'b0 || fwda !== 2'd0 || fwdb !== 2'd0) begin failures++; $display("FAIL mid_rst_outs got=%b%b%0d%0d exp=0000", halted, step_ack, fwda, fwdb); end
    checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL mid_rst_cnt got=%0d exp=0", stall_cnt); end
    halt_req = 1'b0; set_id(0, 0, 0, 0, 0, 0, 0);
    tick(); resetn = 1'b1; tick(); #2;
    checks++; if (pc_we !== 1'b1 || halted !== 1'b0) begin failures++; $display("FAIL mid_rst_run got=%b/%b exp=1/0", pc_we, halted); end
  endtask

  task automatic test_random();
    bit haz, e_pc, e_bub;
    ent_t e;
    do_reset(); m_reset();
    for (int c = 0; c < 800; c++) begin
      set_id($urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1),
             $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3));
      if ($urandom_range(0, 11) == 0) halt_req = ~halt_req;
      step_req = ($urandom_range(0, 3) == 0);
      haz  = hist[0].ld && ((id_uses_rs && hit(hist[0], id_rs)) || (id_uses_rt && hit(hist[0], id_rt)));
      e_pc  = (md == MD_RUN) ? !haz : (md == MD_STEP);
      e_bub = (md == MD_RUN) ? haz : (md != MD_STEP);
      #2;
      checks++; if (pc_we !== e_pc || idex_bubble !== e_bub) begin failures++; $display("FAIL rnd_ctl c=%0d got=%b%b exp=%b%b", c, pc_we, idex_bubble, e_pc, e_bub); end
      checks++; if (fwda !== m_fwd(id_rs) || fwdb !== m_fwd(id_rt)) begin failures++; $display("FAIL rnd_fwd c=%0d got=%0d/%0d exp=%0d/%0d", c, fwda, fwdb, m_fwd(id_rs), m_fwd(id_rt)); end
      checks++; if (halted !== (md == MD_HALT) || step_ack !== 1'(m_ack)) begin failures++; $display("FAIL rnd_dbg c=%0d got=%b%b exp=%b%0d", c, halted, step_ack, md == MD_HALT, m_ack); end
      checks++; if (stall_cnt !== 16'(m_cnt)) begin failures++; $display("FAIL rnd_cnt c=%0d got=%0d exp=%0d", c, stall_cnt, m_cnt); end
      tick();
      e = '{0, 0, 0};
      if (e_pc && !e_bub) e = '{id_wreg, id_rn, id_m2reg};
      hist.push_front(e); void'(hist.pop_back());
      m_ack = 0;
      case (md)
        MD_RUN: begin
          if (haz && m_cnt < 65535) m_cnt++;
          if (halt_req) begin md = MD_DRAIN; left = 3; end
        end
        MD_DRAIN: begin
          left--;
          if (left == 0) begin md = MD_HALT; m_ack = pend; pend = 0; end
        end
        MD_HALT: begin
          if (!halt_req) md = MD_RUN;
          else if (STEP_EN && step_req) md = MD_STEP;
        end
        default: begin md = MD_DRAIN; left = 3; pend = 1; end
      endcase
    end
    halt_req = 1'b0; step_req = 1'b0;
  endtask

  initial begin
    halt_req = 1'b0; step_req = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_load_use();
    test_forward();
    test_halt();
    test_step();
    test_saturate();
    test_reset_mid_drain();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
